thunderbolt_cmd_tx: RTL and testbench

// - TSIP command transmitter toward the Thunderbolt GPS; drives o_tx_thunder (RS232, 8N1, LSB first, idle high).
// - Latches command ID plus 0..MAX_PAYLOAD payload bytes on i_start and sends one framed packet:
//   DLE, ID, payload (DLE-stuffed), DLE, ETX. Sits beside the thunderbolt receive path in the thunderbolt block.

---
 rtl/thunderbolt_pkg.sv | 30 +++
 rtl/thunderbolt_uart_tx.sv | 103 ++++++++++
 rtl/thunderbolt_cmd_tx.sv | 167 ++++++++++++++++
 tb/tb_thunderbolt_cmd_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/thunderbolt_pkg.sv
// Shared TSIP framing constants and state types for the thunderbolt transmit/receive paths.
package thunderbolt_pkg;

    localparam logic [7:0] TSIP_DLE = 8'h10;
    localparam logic [7:0] TSIP_ETX = 8'h03;

    // One UART character: start bit, data bits, stop bit.
    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_DATA_BITS  = UART_FRAME_BITS - 2;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_HDR_DLE,
        TX_ID,
        TX_ID_STUFF,
        TX_DATA,
        TX_DATA_STUFF,
        TX_TRL_DLE,
        TX_ETX,
        TX_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

endpackage

// File: rtl/thunderbolt_uart_tx.sv
// 8N1 UART transmitter: one byte per i_dv, LSB first, line idles high.
module thunderbolt_uart_tx
    import thunderbolt_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dv,
    input  logic [7:0] i_byte,
    output logic       o_active,
    output logic       o_done,
    output logic       o_tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d;
    logic             done_d;

    // State, counters and registered line/status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= UART_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            o_tx     <= 1'b1;
            o_done   <= 1'b0;
            o_active <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            o_tx     <= tx_d;
            o_done   <= done_d;
            o_active <= (state_d != UART_IDLE);
        end
    end

    // Bit sequencing; line value follows the current state one cycle later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            UART_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (i_dv) begin
                    shift_d = i_byte;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                tx_d = 1'b0;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = UART_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = UART_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/thunderbolt_cmd_tx.sv
// TSIP command transmitter: frames DLE, ID, stuffed payload, DLE, ETX onto the Thunderbolt serial line.
module thunderbolt_cmd_tx
    import thunderbolt_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned MAX_PAYLOAD  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [7:0]               i_cmd_id,
    input  logic [3:0]               i_len,
    input  logic [8*MAX_PAYLOAD-1:0] i_payload,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_tx_thunder
);

    localparam int unsigned IDX_W = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned SEL_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] len_sat_c;
    logic [7:0]       cmd_q;
    logic [7:0]       payload_q [MAX_PAYLOAD];
    logic             sent_q, sent_d;
    logic             accept_c;
    logic             dv_c;
    logic [7:0]       tx_byte_c;
    logic [7:0]       data_byte_c;
    logic             last_c;
    logic             busy_d;
    logic             done_d;
    logic             uart_active;
    logic             uart_done;

    // Requested length clamped to the buffer depth.
    assign len_sat_c = (32'(i_len) > MAX_PAYLOAD) ? IDX_W'(MAX_PAYLOAD) : IDX_W'(i_len);

    // Framing state, byte index, request buffer and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= TX_IDLE;
            idx_q   <= '0;
            sent_q  <= 1'b0;
            cmd_q   <= '0;
            len_q   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            for (int k = 0; k < int'(MAX_PAYLOAD); k++) begin
                payload_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sent_q  <= sent_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
            if (accept_c) begin
                cmd_q <= i_cmd_id;
                len_q <= len_sat_c;
                for (int k = 0; k < int'(MAX_PAYLOAD); k++) begin
                    payload_q[k] <= i_payload[8*k +: 8];
                end
            end
        end
    end

    // Next frame state; each byte state hands one byte to the UART and waits for its done pulse.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sent_d      = sent_q;
        accept_c    = 1'b0;
        dv_c        = 1'b0;
        tx_byte_c   = TSIP_DLE;
        data_byte_c = payload_q[idx_q[SEL_W-1:0]];
        last_c      = ((idx_q + IDX_W'(1)) == len_q);

        // Issue exactly one byte per state visit.
        if ((state_q != TX_IDLE) && (state_q != TX_DONE)) begin
            if (!sent_q && !uart_active) begin
                dv_c   = 1'b1;
                sent_d = 1'b1;
            end
            if (uart_done) begin
                sent_d = 1'b0;
            end
        end

        case (state_q)
            TX_IDLE, TX_DONE: begin
                if (i_start && !o_busy) begin
                    accept_c = 1'b1;
                    idx_d    = '0;
                    sent_d   = 1'b0;
                    state_d  = TX_HDR_DLE;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_HDR_DLE: begin
                if (uart_done) state_d = TX_ID;
            end
            TX_ID: begin
                tx_byte_c = cmd_q;
                if (uart_done) begin
                    idx_d = '0;
                    if (cmd_q == TSIP_DLE)  state_d = TX_ID_STUFF;
                    else if (len_q == '0)   state_d = TX_TRL_DLE;
                    else                    state_d = TX_DATA;
                end
            end
            TX_ID_STUFF: begin
                if (uart_done) state_d = (len_q == '0) ? TX_TRL_DLE : TX_DATA;
            end
            TX_DATA: begin
                tx_byte_c = data_byte_c;
                if (uart_done) begin
                    if (data_byte_c == TSIP_DLE) begin
                        state_d = TX_DATA_STUFF;
                    end else if (last_c) begin
                        state_d = TX_TRL_DLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            TX_DATA_STUFF: begin
                if (uart_done) begin
                    if (last_c) begin
                        state_d = TX_TRL_DLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = TX_DATA;
                    end
                end
            end
            TX_TRL_DLE: begin
                if (uart_done) state_d = TX_ETX;
            end
            TX_ETX: begin
                tx_byte_c = TSIP_ETX;
                if (uart_done) state_d = TX_DONE;
            end
            default: state_d = TX_IDLE;
        endcase

        busy_d = (state_d != TX_IDLE) && (state_d != TX_DONE);
        done_d = (state_d == TX_DONE);
    end

    thunderbolt_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_dv    (dv_c),
        .i_byte  (tx_byte_c),
        .o_active(uart_active),
        .o_done  (uart_done),
        .o_tx    (o_tx_thunder)
    );

endmodule

// File: tb/tb_thunderbolt_cmd_tx.sv
// Directed bench for thunderbolt_cmd_tx: serial decode of the line plus frame/handshake checks.
module tb_thunderbolt_cmd_tx;

    localparam int C   = 4;
    localparam int MAX = 8;

    logic             clk;
    logic             i_rst;
    logic             i_start;
    logic [7:0]       i_cmd_id;
    logic [3:0]       i_len;
    logic [8*MAX-1:0] i_payload;
    logic             o_busy;
    logic             o_done;
    logic             o_tx_thunder;

    int         n_checks;
    int         n_errors;
    int         rx_cnt;
    int         done_cnt;
    logic [7:0] rx_mem [0:255];

    thunderbolt_cmd_tx #(
        .CLKS_PER_BIT(C),
        .MAX_PAYLOAD (MAX)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_cmd_id    (i_cmd_id),
        .i_len       (i_len),
        .i_payload   (i_payload),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_tx_thunder(o_tx_thunder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Serial monitor: decodes 8N1 characters and checks every bit lasts exactly C cycles.
    initial begin : serial_mon
        int s;
        int bi;
        logic lvl;
        logic ok;
        logic active;
        logic [7:0] sh;
        s = 0; bi = 0; lvl = 1'b1; ok = 1'b1; active = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                active = 1'b0;
            end else begin
                if (!active && o_tx_thunder === 1'b0) begin
                    active = 1'b1;
                    s = 0;
                end
                if (active) begin
                    if (s % C == 0) begin
                        lvl = o_tx_thunder;
                        ok  = 1'b1;
                    end else if (o_tx_thunder !== lvl) begin
                        ok = 1'b0;
                    end
                    if (s % C == C - 1) begin
                        bi = s / C;
                        if (bi == 0) begin
                            check("start_bit", {ok, lvl}, 2'b10);
                        end else if (bi == 9) begin
                            check("stop_bit", {ok, lvl}, 2'b11);
                            rx_mem[rx_cnt[7:0]] = sh;
                            rx_cnt++;
                            active = 1'b0;
                        end else begin
                            check("data_bit_width", ok, 1'b1);
                            sh[bi-1] = lvl;
                        end
                    end
                    s++;
                end
            end
        end
    end

    // o_done pulse counter.
    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (o_done === 1'b1) done_cnt++;
        end
    end

    // Present a request for one cycle; returns at the negedge after the accept edge.
    task automatic start_req(input logic [7:0] id, input logic [3:0] len, input logic [63:0] pl);
        @(negedge clk);
        i_cmd_id  = id;
        i_len     = len;
        i_payload = pl;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
        i_cmd_id  = 8'hFF;
        i_len     = 4'hF;
        i_payload = '1;
    endtask

    // Send one frame and compare the decoded bytes against exp_v (send order, left-justified).
    task automatic send_frame(input string tag, input logic [7:0] id, input logic [3:0] len,
                              input logic [63:0] pl, input int exp_n, input logic [127:0] exp_v,
                              input bit mid_start);
        int base_rx;
        int base_done;
        int cyc;
        bit in_range;
        base_rx   = rx_cnt;
        base_done = done_cnt;
        start_req(id, len, pl);
        check({tag, "_busy_after_accept"}, o_busy, 1'b1);
        check({tag, "_line_idle_e0"}, o_tx_thunder, 1'b1);
        @(negedge clk);
        check({tag, "_line_idle_e1"}, o_tx_thunder, 1'b1);
        @(negedge clk);
        check({tag, "_start_bit_e2"}, o_tx_thunder, 1'b0);
        cyc = 2;
        while (o_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mid_start && cyc == 100) begin
                i_cmd_id = 8'h55;
                i_len    = 4'd0;
                i_start  = 1'b1;
            end
            if (mid_start && cyc == 101) i_start = 1'b0;
        end
        check({tag, "_done_seen"}, o_done, 1'b1);
        check({tag, "_busy_at_done"}, o_busy, 1'b0);
        in_range = (cyc >= exp_n * 10 * C) && (cyc <= exp_n * 10 * C + 2 * exp_n + 3);
        check({tag, "_duration_ok"}, in_range, 1'b1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, o_done, 1'b0);
        repeat (60) @(negedge clk);
        check({tag, "_byte_count"}, rx_cnt - base_rx, exp_n);
        check({tag, "_done_pulses"}, done_cnt - base_done, 1);
        check({tag, "_busy_after"}, o_busy, 1'b0);
        check({tag, "_line_idle_after"}, o_tx_thunder, 1'b1);
        for (int k = 0; k < exp_n; k++) begin
            if (base_rx + k < rx_cnt) begin
                check($sformatf("%s_byte%0d", tag, k), rx_mem[(base_rx + k) % 256], exp_v[127-8*k -: 8]);
            end
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base_rx;
        int base_done;
        n_checks  = 0;
        n_errors  = 0;
        rx_cnt    = 0;
        done_cnt  = 0;
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_cmd_id  = '0;
        i_len     = '0;
        i_payload = '0;

        repeat (3) @(negedge clk);
        check("rst_line", o_tx_thunder, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_line", o_tx_thunder, 1'b1);
        check("idle_busy", o_busy, 1'b0);

        send_frame("id21", 8'h21, 4'd0, 64'h0, 4,
                   {8'h10, 8'h21, 8'h10, 8'h03, 96'h0}, 1'b0);
        send_frame("len1", 8'h8E, 4'd1, 64'hA5, 5,
                   {8'h10, 8'h8E, 8'hA5, 8'h10, 8'h03, 88'h0}, 1'b0);
        send_frame("stuff", 8'h8E, 4'd3, 64'h100310, 9,
                   {8'h10, 8'h8E, 8'h10, 8'h10, 8'h03, 8'h10, 8'h10, 8'h10, 8'h03, 56'h0}, 1'b0);
        send_frame("id10", 8'h10, 4'd0, 64'h0, 5,
                   {8'h10, 8'h10, 8'h10, 8'h10, 8'h03, 88'h0}, 1'b0);
        send_frame("clamp", 8'h3A, 4'd12, 64'h0807060504030201, 12,
                   {8'h10, 8'h3A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                    8'h07, 8'h08, 8'h10, 8'h03, 32'h0}, 1'b1);

        // Abort during the third byte (which starts 86 cycles after accept).
        base_rx   = rx_cnt;
        base_done = done_cnt;
        start_req(8'h8E, 4'd1, 64'hA5);
        repeat (94) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("abort_line_high", o_tx_thunder, 1'b1);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        i_rst = 1'b0;
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt - base_done, 0);
        check("abort_bytes", rx_cnt - base_rx, 2);
        check("abort_line_idle", o_tx_thunder, 1'b1);

        send_frame("post_rst", 8'h8E, 4'd1, 64'hA5, 5,
                   {8'h10, 8'h8E, 8'hA5, 8'h10, 8'h03, 88'h0}, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
